// File: rtl/mem_pkg.sv
// Shared constants and types for the MEM key sequencer.
package mem_pkg;

    localparam int unsigned DEF_SET_W  = 2;
    localparam int unsigned DEF_CHAR_W = 8;

    localparam logic [7:0] CH_UA    = 8'h41;
    localparam logic [7:0] CH_UZ    = 8'h5A;
    localparam logic [7:0] CH_LA    = 8'h61;
    localparam logic [7:0] CH_LZ    = 8'h7A;
    localparam logic [7:0] CASE_OFS = 8'h20;

    typedef enum logic {
        UNKEYED = 1'b0,
        RUN     = 1'b1
    } state_t;

endpackage

// File: rtl/mem_char_filter.sv
// Classifies an ASCII character as a letter and folds lowercase to uppercase.
module mem_char_filter
    import mem_pkg::*;
#(
    parameter int unsigned CHAR_W = DEF_CHAR_W
) (
    input  logic [CHAR_W-1:0] char_i,
    output logic              is_letter_c_o,
    output logic [CHAR_W-1:0] upper_char_c_o
);

    logic is_upper;
    logic is_lower;

    // Range compare against the ASCII letter bounds, fold lowercase down by 0x20.
    always_comb begin
        is_upper       = (char_i >= CHAR_W'(CH_UA)) && (char_i <= CHAR_W'(CH_UZ));
        is_lower       = (char_i >= CHAR_W'(CH_LA)) && (char_i <= CHAR_W'(CH_LZ));
        is_letter_c_o  = is_upper || is_lower;
        upper_char_c_o = is_lower ? (char_i - CHAR_W'(CASE_OFS)) : char_i;
    end

endmodule

// File: rtl/mem_key_sequencer.sv
// Filters a character stream to letters and pairs each with the next key setting.
module mem_key_sequencer
    import mem_pkg::*;
#(
    parameter int unsigned KEY_LEN = 4,
    parameter int unsigned SET_W   = DEF_SET_W,
    parameter int unsigned CHAR_W  = DEF_CHAR_W,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     key_load,
    input  logic [KEY_LEN*SET_W-1:0] key_in,
    input  logic                     msg_start,
    input  logic                     in_valid,
    input  logic [CHAR_W-1:0]        in_char,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [CHAR_W-1:0]        out_char,
    output logic [SET_W-1:0]         out_setting,
    input  logic                     out_ready,
    output logic                     bad_char,
    output logic [CNT_W-1:0]         msg_len
);

    localparam int unsigned KEY_W = KEY_LEN * SET_W;
    localparam int unsigned IDX_W = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KEY_LEN - 1);

    state_t             state_q, state_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               out_valid_q, out_valid_d;
    logic [CHAR_W-1:0]  out_char_q, out_char_d;
    logic [SET_W-1:0]   out_setting_q, out_setting_d;
    logic               bad_char_q, bad_char_d;
    logic [CNT_W-1:0]   msg_len_q, msg_len_d;

    logic               is_letter;
    logic [CHAR_W-1:0]  upper_char;
    logic [IDX_W-1:0]   slot;
    logic [SET_W-1:0]   setting_sel;
    logic [CNT_W-1:0]   len_base;
    logic               accept;

    mem_char_filter #(
        .CHAR_W (CHAR_W)
    ) u_filter (
        .char_i         (in_char),
        .is_letter_c_o  (is_letter),
        .upper_char_c_o (upper_char)
    );

    // Input is taken only once keyed, never during a key load, and only when the output stage frees up.
    assign in_ready = (state_q == RUN) && !key_load && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // A message restart forces this letter onto slot 0.
    always_comb begin
        slot        = msg_start ? '0 : idx_q;
        setting_sel = '0;
        for (int unsigned i = 0; i < KEY_LEN; i++) begin
            if (slot == IDX_W'(i)) begin
                setting_sel = key_q[i*SET_W +: SET_W];
            end
        end
        len_base = msg_start ? '0 : msg_len_q;
    end

    // Next-state logic for the FSM, key, slot index, counter and output stage.
    always_comb begin
        state_d       = state_q;
        key_d         = key_q;
        idx_d         = idx_q;
        out_valid_d   = out_valid_q && !out_ready;
        out_char_d    = out_char_q;
        out_setting_d = out_setting_q;
        bad_char_d    = 1'b0;
        msg_len_d     = msg_len_q;

        if (key_load) begin
            state_d   = RUN;
            key_d     = key_in;
            idx_d     = '0;
            msg_len_d = '0;
        end else begin
            if (msg_start) begin
                idx_d     = '0;
                msg_len_d = '0;
            end
            if (accept) begin
                if (is_letter) begin
                    out_valid_d   = 1'b1;
                    out_char_d    = upper_char;
                    out_setting_d = setting_sel;
                    idx_d         = (slot == LAST_IDX) ? '0 : slot + IDX_W'(1);
                    msg_len_d     = (&len_base) ? len_base : len_base + CNT_W'(1);
                end else begin
                    bad_char_d = 1'b1;
                end
            end
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= UNKEYED;
            key_q         <= '0;
            idx_q         <= '0;
            out_valid_q   <= 1'b0;
            out_char_q    <= '0;
            out_setting_q <= '0;
            bad_char_q    <= 1'b0;
            msg_len_q     <= '0;
        end else begin
            state_q       <= state_d;
            key_q         <= key_d;
            idx_q         <= idx_d;
            out_valid_q   <= out_valid_d;
            out_char_q    <= out_char_d;
            out_setting_q <= out_setting_d;
            bad_char_q    <= bad_char_d;
            msg_len_q     <= msg_len_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_char    = out_char_q;
    assign out_setting = out_setting_q;
    assign bad_char    = bad_char_q;
    assign msg_len     = msg_len_q;

endmodule
